// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU report an error.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   opnd_q;  // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;   // {partial product, multiplier} or {remainder, quotient}
    logic               neg_q;
    logic               err_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               signed_op, is_mul, is_mt;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mul_next, acc_d, prod;
    logic [WIDTH-1:0]   hi_fin, lo_fin;

    assign signed_op = ~op[0];
    assign is_mul    = (op[2:1] == 2'b00);
    assign is_mt     = (op[2:1] == 2'b10);
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    assign mul_next = {sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic               div_q;
    logic               rneg_q;
    logic               is_div;
    logic [WIDTH:0]     shifted, diff;
    logic [2*WIDTH-1:0] div_next;

    assign is_div  = (op[2:1] == 2'b01);
    // Remainder stays below the divisor, so a successful trial difference fits in WIDTH bits.
    assign shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, opnd_q};
    assign div_next = diff[WIDTH] ? {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
`endif

    always_comb begin
        acc_d  = mul_next;
        prod   = neg_q ? -mul_next : mul_next;
        hi_fin = prod[2*WIDTH-1:WIDTH];
        lo_fin = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (div_q) begin
            acc_d  = div_next;
            lo_fin = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
            hi_fin = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= StDone;
                        err_q   <= 1'b0;
                        hi_q    <= hi_fin;
                        lo_q    <= lo_fin;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    if (start) begin
                        if (is_mt) begin
                            if (op[0]) lo_q <= a;
                            else       hi_q <= a;
                        end else if (is_mul) begin
                            state_q <= StRun;
                            cnt_q   <= CW'(WIDTH);
                            opnd_q  <= abs_a;
                            acc_q   <= {{WIDTH{1'b0}}, abs_b};
                            neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                            div_q   <= 1'b0;
                        end else if (is_div && (b != '0)) begin
                            state_q <= StRun;
                            cnt_q   <= CW'(WIDTH);
                            opnd_q  <= abs_b;
                            acc_q   <= {{WIDTH{1'b0}}, abs_a};
                            neg_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_q  <= signed_op & a[WIDTH-1];
                            div_q   <= 1'b1;
`endif
                        end else begin
                            state_q <= StDone;
                            err_q   <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign err  = err_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit; expectations follow the MULDIV_DIV_EN setting.
module tb_muldiv_unit;
    localparam int unsigned W = 32;
    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MTHI = 3'b100, MTLO = 3'b101, ILL = 3'b110;
`ifdef MULDIV_DIV_EN
    localparam int DIV_LAT = 33;
    localparam logic [2:0] ABORT_OP = DIVU;
`else
    localparam int DIV_LAT = 1;
    localparam logic [2:0] ABORT_OP = MULTU;
`endif

    logic         clk = 1'b0;
    logic         rst_n, start, busy, done, err;
    logic [2:0]   op;
    logic [W-1:0] a, b, hi, lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .hi(hi), .lo(lo)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         err;
    } res_t;

    res_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        res_t         r;
        longint       sx, sy, q, rm;
        logic [63:0]  p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.hi = cur_hi;
        r.lo = cur_lo;
        r.err = 1'b1;
        case (o)
            MULT: begin
                p = 64'(sx * sy);
                {r.hi, r.lo} = p;
                r.err = 1'b0;
            end
            MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                {r.hi, r.lo} = p;
                r.err = 1'b0;
            end
`ifdef MULDIV_DIV_EN
            DIV, DIVU: begin
                if (y != '0) begin
                    if (o == DIVU) begin
                        sx = longint'({32'b0, x});
                        sy = longint'({32'b0, y});
                    end
                    q  = sx / sy;
                    rm = sx % sy;
                    r.lo = q[W-1:0];
                    r.hi = rm[W-1:0];
                    r.err = 1'b0;
                end
            end
`endif
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Drive at a negedge; returns at the negedge of cycle 1 with operands scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (o == MTHI)      cur_hi = x;
        else if (o == MTLO) cur_lo = x;
        else                sb.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        a     = ~x;
        b     = ~y;
    endtask

    task automatic finish_op(input string tag, input int lat0, input int exp_lat);
        int   lat;
        int   bc;
        res_t e;
        lat = lat0;
        bc  = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, W'(lat), W'(exp_lat));
        chk({tag, " busy cycles"}, W'(bc), W'(exp_lat - lat0));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed done expected none", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, hi, e.hi);
            chk({tag, " lo"}, lo, e.lo);
            chk({tag, " err"}, W'(err), W'(e.err));
            cur_hi = e.hi;
            cur_lo = e.lo;
        end
    endtask

    initial begin
        int nd;
        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", W'(busy), '0);
        chk("reset done", W'(done), '0);
        chk("reset err", W'(err), '0);
        chk("reset hi", hi, '0);
        chk("reset lo", lo, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // MULT -3 * 5
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        chk("mult busy c1", W'(busy), 32'd1);
        finish_op("mult", 1, 33);
        chk("mult hi const", hi, 32'hFFFF_FFFF);
        chk("mult lo const", lo, 32'hFFFF_FFF1);
        @(negedge clk);
        chk("mult done one cycle", W'(done), '0);

        // MULTU max*max with an ignored MTHI start in cycle 10
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        start = 1'b1;
        op    = MTHI;
        a     = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        finish_op("multu", 11, 33);
        chk("multu hi const", hi, 32'hFFFF_FFFE);
        chk("multu lo const", lo, 32'h0000_0001);

        for (int i = 0; i < 4; i++) begin
            issue((i % 2 == 0) ? MULT : MULTU, W'($urandom), W'($urandom));
            finish_op("rand mul", 1, 33);
        end

        // Signed divides including the overflow case
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        finish_op("div -7/2", 1, DIV_LAT);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div ovf", 1, DIV_LAT);
        issue(DIV, W'($urandom), 32'd13);
        finish_op("div rand", 1, DIV_LAT);

        // MT ops, then divide-by-zero and plain DIVU
        issue(MTHI, 32'h1234_5678, 32'd0);
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi no done", W'(done), '0);
        issue(MTLO, 32'hCAFE_F00D, 32'd0);
        chk("mtlo lo", lo, 32'hCAFE_F00D);
        issue(DIVU, 32'd100, 32'd0);
        finish_op("divu by 0", 1, 1);
        chk("divu by 0 hi", hi, 32'h1234_5678);
        issue(DIVU, 32'd100, 32'd3);
        finish_op("divu 100/3", 1, DIV_LAT);
        issue(ILL, 32'd1, 32'd1);
        finish_op("illegal", 1, 1);

        // Reset during RUN aborts
        issue(ABORT_OP, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", W'(busy), '0);
        chk("abort done", W'(done), '0);
        chk("abort hi", hi, '0);
        chk("abort lo", lo, '0);
        void'(sb.pop_front());
        cur_hi = '0;
        cur_lo = '0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        chk("abort no done", W'(nd), '0);

        // Back-to-back issue in the DONE cycle
        issue(MULTU, 32'd6, 32'd7);
        finish_op("b2b first", 1, 33);
        chk("b2b first lo", lo, 32'd42);
        issue(MULTU, 32'd2, 32'd3);
        chk("b2b busy c1", W'(busy), 32'd1);
        finish_op("b2b second", 1, 33);
        chk("b2b second lo", lo, 32'd6);
        chk("b2b second hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits beside the combinational ALU in the execute stage and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. Arithmetic runs iteratively, one bit per cycle, with a start/busy/done handshake so the control path can stall on MFHI/MFLO. HI and LO are exposed continuously for MFHI/MFLO reads.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when the unit is accepting (see Operation).
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 illegal.
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  iteration in progress; new starts ignored.
- done  out  1  one-cycle pulse: result or error is now visible.
- err  out  1  valid only with done: divide-by-zero, illegal op, or divide compiled out.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered-state decodes: busy = (RUN); done = (DONE); err is a register cleared whenever DONE is entered without an error.
- Accepting: IDLE or DONE. start with !accepting is ignored, with no side effect.
- Accepted MTHI/MTLO: write a to hi/lo at the sampling edge; stay in or return to IDLE; no done.
- Accepted MULT/MULTU/DIV/DIVU (b≠0 for divides): latch |a| and |b| (raw for unsigned), result signs and counter=WIDTH; go to RUN.
- RUN: one shift-add step (multiply) or one restoring subtract step (divide) per cycle; counter decrements. On the edge where the counter reaches 0, write sign-corrected results to hi/lo and go to DONE.
- Multiply: {hi,lo} = full 2·WIDTH product, two's complement for MULT.
- Divide: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Signed overflow (a = most-negative, b = −1): lo = most-negative, hi = 0, err = 0.
- Divide-by-zero or illegal op: go straight to DONE with err = 1. hi/lo are unchanged.
- DONE lasts exactly one cycle. Then go to IDLE, or to RUN/DONE if a new start is accepted in it.
- Operands a and b may change after the accept edge without affecting the result.

## Timing
- Reset: state IDLE, busy = 0, done = 0, err = 0, hi = 0, lo = 0, counter = 0.
- Reset takes priority over start in the same cycle. Reset during RUN aborts the operation; no done pulse is produced.
- start accepted at edge E0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1, with hi/lo already updated.
- Back-to-back: start in the DONE cycle gives busy in the next cycle; throughput is one op per WIDTH+1 cycles.
- Error/illegal path: done and err are high in cycle 1 after the accept.
- MTHI/MTLO: hi/lo visible in cycle 1.
- Unit latency is fixed and is independent of operand values; there is no early termination.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath and DIV/DIVU are supported as above.
- MULDIV_DIV_EN undefined: the divider logic is absent. DIV/DIVU behave as illegal ops: done + err in cycle 1, hi/lo unchanged. Multiply and MT ops are identical in both builds.

## Test plan
- MULT with WIDTH = 32, a = 0xFFFFFFFD (−3), b = 5 → done in cycle 33, hi = 0xFFFFFFFF, lo = 0xFFFFFFF1, err = 0, busy high for cycles 1..32.
- MULTU with a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001. A start pulsed in cycle 10 with other operands is ignored and the result is unchanged.
- DIV with a = 0xFFFFFFF9 (−7), b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIV with a = 0x80000000, b = 0xFFFFFFFF → lo = 0x80000000, hi = 0, err = 0.
- MTHI 0x12345678, then DIVU with a = 100, b = 0 → done + err in cycle 1, hi = 0x12345678, lo unchanged. Repeat the DIVU with MULDIV_DIV_EN undefined and b = 3 → same error response.
- DIVU with a = 100, b = 7 starts; rst_n low in cycle 12 → next cycle busy = 0, done = 0, hi = lo = 0. No done pulse ever appears for the aborted op.
- MULTU with a = 6, b = 7, then a new MULTU with a = 2, b = 3 issued in the DONE cycle → first result lo = 42, the second done arrives exactly 33 cycles later with lo = 6, hi = 0.
